// File: rtl/ber_sweep_pkg.sv
// ber_sweep_pkg: shared types for the BER sweep controller.
// Build option: BER_EARLY_STOP_EN enables the error-limit window end.
package ber_sweep_pkg;

    // Widest noise_sel the result record can carry.
    localparam int unsigned BER_SEL_MAX_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        RESET_LINK,
        SETTLE,
        MEASURE,
        REPORT,
        DONE
    } ber_state_t;

    typedef struct packed {
        logic [BER_SEL_MAX_W-1:0] sel;
        logic [31:0]              bits;
        logic [31:0]              errors;
        logic                     timeout;
        logic                     early;
    } ber_result_t;

    // Counter delta that stays correct across a 32-bit wrap.
    function automatic logic [31:0] mod_delta(input logic [31:0] now_v, input logic [31:0] base_v);
        return now_v - base_v;
    endfunction

endpackage

// File: rtl/ber_sweep_ctrl_window.sv
// ber_window_counter: baseline snapshot, modular deltas and end-of-window compares.
// Build option: BER_EARLY_STOP_EN adds the error-limit comparator (else err_end_o = 0).
module ber_window_counter
    import ber_sweep_pkg::*;
#(
    parameter int unsigned WINDOW_BITS = 100000
`ifdef BER_EARLY_STOP_EN
    ,
    parameter int unsigned ERR_LIMIT   = 1000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        snap_i,
    input  logic [31:0] total_bits_i,
    input  logic [31:0] total_err_i,
    output logic [31:0] d_bits_o,
    output logic [31:0] d_err_o,
    output logic        win_end_o,
    output logic        err_end_o
);

    logic [31:0] base_bits_q;
    logic [31:0] base_err_q;

    // Capture the checker counters as the window baseline.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_bits_q <= '0;
            base_err_q  <= '0;
        end else if (snap_i) begin
            base_bits_q <= total_bits_i;
            base_err_q  <= total_err_i;
        end
    end

    assign d_bits_o  = mod_delta(total_bits_i, base_bits_q);
    assign d_err_o   = mod_delta(total_err_i, base_err_q);
    assign win_end_o = (d_bits_o >= 32'(WINDOW_BITS));

`ifdef BER_EARLY_STOP_EN
    assign err_end_o = (d_err_o >= 32'(ERR_LIMIT));
`else
    assign err_end_o = 1'b0;
`endif

endmodule

// File: rtl/ber_sweep_ctrl.sv
// ber_sweep_ctrl: sequences one BER run per noise setting and reports window deltas.
// Build option: BER_EARLY_STOP_EN ends a window early once ERR_LIMIT errors are seen.
module ber_sweep_ctrl
    import ber_sweep_pkg::*;
#(
    parameter int unsigned NUM_SETTINGS   = 8,
    parameter int unsigned SEL_W          = 3,
    parameter int unsigned RST_CYCLES     = 4,
    parameter int unsigned SETTLE_CYCLES  = 64,
    parameter int unsigned WINDOW_BITS    = 100000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned ERR_LIMIT      = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      total_bits,
    input  logic [31:0]      total_bit_errors,
    output logic             link_rstn,
    output logic             link_en,
    output logic [SEL_W-1:0] noise_sel,
    output logic             busy,
    output logic             done,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [SEL_W-1:0] result_sel,
    output logic [31:0]      result_bits,
    output logic [31:0]      result_errors,
    output logic             result_timeout,
    output logic             result_early
);

    localparam logic [31:0]      RST_LAST    = 32'(RST_CYCLES - 1);
    localparam logic [31:0]      SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0]      WD_LAST     = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(NUM_SETTINGS - 1);

    ber_state_t       state_q;
    logic [31:0]      cnt_q;
    logic [SEL_W-1:0] sel_q;
    logic             link_rstn_q;
    logic             link_en_q;
    logic             busy_q;
    logic             done_q;
    logic             valid_q;
    ber_result_t      res_q;
    ber_result_t      res_d;

    logic [31:0] d_bits;
    logic [31:0] d_err;
    logic        win_end;
    logic        err_end;
    logic        snap;
    logic        wd_hit;
    logic        meas_end;

    assign snap     = (state_q == SETTLE) && (cnt_q == SETTLE_LAST);
    assign wd_hit   = (state_q == MEASURE) && (cnt_q >= WD_LAST);
    assign meas_end = win_end || err_end || wd_hit;

    ber_window_counter #(
        .WINDOW_BITS (WINDOW_BITS)
`ifdef BER_EARLY_STOP_EN
        ,
        .ERR_LIMIT   (ERR_LIMIT)
`endif
    ) u_window (
        .clk          (clk),
        .rst          (rst),
        .snap_i       (snap),
        .total_bits_i (total_bits),
        .total_err_i  (total_bit_errors),
        .d_bits_o     (d_bits),
        .d_err_o      (d_err),
        .win_end_o    (win_end),
        .err_end_o    (err_end)
    );

`ifndef BER_EARLY_STOP_EN
    localparam int unsigned unused_err_limit = ERR_LIMIT;
`endif

    // Result record for the current window; a watchdog hit only counts as a
    // timeout when neither the bit window nor the error limit closed it too.
    always_comb begin
        res_d         = '0;
        res_d.sel     = BER_SEL_MAX_W'(sel_q);
        res_d.bits    = d_bits;
        res_d.errors  = d_err;
        res_d.early   = err_end;
        res_d.timeout = wd_hit && !win_end && !err_end;
    end

    // Sweep sequencer: state, shared phase/watchdog counter, link controls, result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            link_rstn_q <= 1'b0;
            link_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            res_q       <= '0;
        end else if (abort) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            link_rstn_q <= 1'b0;
            link_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            res_q       <= '0;
        end else begin
            cnt_q <= cnt_q + 32'd1;
            unique case (state_q)
                IDLE, DONE: begin
                    cnt_q <= '0;
                    if (start) begin
                        state_q <= RESET_LINK;
                        sel_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                RESET_LINK: begin
                    if (cnt_q == RST_LAST) begin
                        state_q     <= SETTLE;
                        cnt_q       <= '0;
                        link_rstn_q <= 1'b1;
                        link_en_q   <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (snap) begin
                        state_q <= MEASURE;
                        cnt_q   <= '0;
                    end
                end
                MEASURE: begin
                    if (meas_end) begin
                        state_q   <= REPORT;
                        cnt_q     <= '0;
                        link_en_q <= 1'b0;
                        valid_q   <= 1'b1;
                        res_q     <= res_d;
                    end
                end
                REPORT: begin
                    if (result_ready) begin
                        cnt_q       <= '0;
                        valid_q     <= 1'b0;
                        link_rstn_q <= 1'b0;
                        if (sel_q == SEL_LAST) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RESET_LINK;
                            sel_q   <= sel_q + SEL_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The result record carries a fixed-width sel; bits above SEL_W are always zero.
    if (SEL_W < BER_SEL_MAX_W) begin : g_sel_pad
        logic unused_sel_hi;
        assign unused_sel_hi = ^res_q.sel[BER_SEL_MAX_W-1:SEL_W];
    end

    assign link_rstn      = link_rstn_q;
    assign link_en        = link_en_q;
    assign noise_sel      = sel_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign result_valid   = valid_q;
    assign result_sel     = res_q.sel[SEL_W-1:0];
    assign result_bits    = res_q.bits;
    assign result_errors  = res_q.errors;
    assign result_timeout = res_q.timeout;
    assign result_early   = res_q.early;

endmodule

// File: tb/tb_ber_sweep_ctrl.sv
// tb_ber_sweep_ctrl: randomized sweep against a cycle-history reference model.
// Build option: BER_EARLY_STOP_EN (must match the RTL build) enables early-stop expectations.
module tb_ber_sweep_ctrl;

    localparam int NS   = 8;
    localparam int SW   = 3;
    localparam int RSTC = 4;
    localparam int SETC = 64;
    localparam int WIN  = 1000;
    localparam int TO   = 1500;
    localparam int ERRL = 5;
`ifdef BER_EARLY_STOP_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          ready;
    logic [31:0]   tb_bits;
    logic [31:0]   tb_err;
    logic          link_rstn;
    logic          link_en;
    logic [SW-1:0] noise_sel;
    logic          busy;
    logic          done;
    logic          result_valid;
    logic [SW-1:0] result_sel;
    logic [31:0]   result_bits;
    logic [31:0]   result_errors;
    logic          result_timeout;
    logic          result_early;

    ber_sweep_ctrl #(
        .NUM_SETTINGS   (NS),
        .SEL_W          (SW),
        .RST_CYCLES     (RSTC),
        .SETTLE_CYCLES  (SETC),
        .WINDOW_BITS    (WIN),
        .TIMEOUT_CYCLES (TO),
        .ERR_LIMIT      (ERRL)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .total_bits       (tb_bits),
        .total_bit_errors (tb_err),
        .link_rstn        (link_rstn),
        .link_en          (link_en),
        .noise_sel        (noise_sel),
        .busy             (busy),
        .done             (done),
        .result_valid     (result_valid),
        .result_ready     (ready),
        .result_sel       (result_sel),
        .result_bits      (result_bits),
        .result_errors    (result_errors),
        .result_timeout   (result_timeout),
        .result_early     (result_early)
    );

    always #5 clk = ~clk;

    // Counter values seen by the DUT at each rising edge, indexed by edge number.
    int          cyc = 0;
    logic [31:0] hb [0:65535];
    logic [31:0] he [0:65535];
    always @(posedge clk) begin
        hb[cyc] = tb_bits;
        he[cyc] = tb_err;
        cyc = cyc + 1;
    end

    // Checker-counter stimulus: rate bits per cycle, errors per 100 bits or per cycle.
    logic [31:0] rate;
    logic [31:0] gen;
    bit          epc;
    int          n_vec;
    int          n_bad;

    task automatic tick();
        logic [31:0] g0;
        @(negedge clk);
        g0      = gen;
        gen     = gen + rate;
        tb_bits = tb_bits + rate;
        if (epc) begin
            if (rate != 32'd0) tb_err = tb_err + 32'd1;
        end else begin
            tb_err = tb_err + (gen / 32'd100 - g0 / 32'd100);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    endtask

    // Reference: the setting entered at edge s snapshots at s+RSTC+SETC; measurement
    // edge m compares deltas against the window, the error limit and the m-th cycle budget.
    task automatic model_result(input int s, output int end_e, output logic [31:0] eb,
                                output logic [31:0] ee, output logic et, output logic ea);
        int p;
        p     = s + RSTC + SETC;
        end_e = -1;
        eb    = '0;
        ee    = '0;
        et    = 1'b0;
        ea    = 1'b0;
        for (int m = 0; m < TO; m++) begin
            int          e;
            logic [31:0] db;
            logic [31:0] de;
            bit          wdone;
            bit          edone;
            bit          tdone;
            e = p + 1 + m;
            if (e >= cyc) break;
            db    = hb[e] - hb[p];
            de    = he[e] - he[p];
            wdone = (db >= 32'(WIN));
            edone = EARLY && (de >= 32'(ERRL));
            tdone = (m == TO - 1);
            if (wdone || edone || tdone) begin
                end_e = e;
                eb    = db;
                ee    = de;
                ea    = edone;
                et    = tdone && !wdone && !edone;
                break;
            end
        end
    endtask

    // One setting entered at edge s; mode 0 handshake, 1 abort in MEASURE, 2 abort+ready in REPORT.
    task automatic run_setting(input int s, input int k, input int bp, input int mode, output int h);
        int          lo;
        int          t;
        int          end_e;
        logic [31:0] eb;
        logic [31:0] ee;
        logic        et;
        logic        ea;
        bit          last;
        h  = -1;
        lo = 0;
        check("sel_entry", 32'(noise_sel), 32'(k));
        check("en_in_reset", 32'(link_en), 32'd0);
        while (link_rstn == 1'b0 && lo < 10) begin
            lo++;
            tick();
        end
        check("rst_len", 32'(lo), 32'(RSTC));
        check("en_on", 32'(link_en), 32'd1);
        if (mode == 1) begin
            repeat (100) tick();
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_rstn", 32'(link_rstn), 32'd0);
            check("abort_en", 32'(link_en), 32'd0);
            check("abort_valid", 32'(result_valid), 32'd0);
            check("abort_sel_hold", 32'(noise_sel), 32'(k));
            return;
        end
        t = 0;
        while (result_valid !== 1'b1 && t < SETC + TO + 16) begin
            tick();
            t++;
        end
        if (result_valid !== 1'b1) begin
            check("valid_wait", 32'(result_valid), 32'd1);
            finish_run();
        end
        model_result(s, end_e, eb, ee, et, ea);
        check("end_edge", 32'(cyc - 1), 32'(end_e));
        check("res_sel", 32'(result_sel), 32'(k));
        check("res_bits", result_bits, eb);
        check("res_errors", result_errors, ee);
        check("res_timeout", 32'(result_timeout), 32'(et));
        check("res_early", 32'(result_early), 32'(ea));
        check("en_in_report", 32'(link_en), 32'd0);
        check("busy_in_report", 32'(busy), 32'd1);
        if (mode == 2) begin
            abort = 1'b1;
            ready = 1'b1;
            tick();
            abort = 1'b0;
            ready = 1'b0;
            check("abhs_valid", 32'(result_valid), 32'd0);
            check("abhs_busy", 32'(busy), 32'd0);
            check("abhs_sel_hold", 32'(noise_sel), 32'(k));
            check("abhs_res_cleared", result_bits, 32'd0);
            return;
        end
        for (int i = 0; i < bp; i++) begin
            tick();
            check("bp_bits", result_bits, eb);
            check("bp_errors", result_errors, ee);
            check("bp_valid", 32'(result_valid), 32'd1);
            check("bp_sel", 32'(noise_sel), 32'(k));
        end
        ready = 1'b1;
        h     = cyc;
        tick();
        ready = 1'b0;
        last  = (k == NS - 1);
        check("valid_drop", 32'(result_valid), 32'd0);
        check("done_after_hs", 32'(done), 32'(last));
        check("busy_after_hs", 32'(busy), 32'(!last));
        check("rstn_after_hs", 32'(link_rstn), 32'd0);
        if (!last) check("sel_advance", 32'(noise_sel), 32'(k + 1));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rstn"}, 32'(link_rstn), 32'd0);
        check({tag, "_en"}, 32'(link_en), 32'd0);
        check({tag, "_sel"}, 32'(noise_sel), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_valid"}, 32'(result_valid), 32'd0);
        check({tag, "_rsel"}, 32'(result_sel), 32'd0);
        check({tag, "_rbits"}, result_bits, 32'd0);
        check({tag, "_rerr"}, result_errors, 32'd0);
        check({tag, "_rto"}, 32'(result_timeout), 32'd0);
        check({tag, "_rearly"}, 32'(result_early), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got time %0t expected completion", $time);
        $fatal(1, "bench time limit");
    end

    initial begin
        int s;
        int h;
        int bp;
        int vcount;
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        ready   = 1'b0;
        rate    = 32'd1;
        epc     = 1'b0;
        gen     = '0;
        tb_bits = '0;
        tb_err  = '0;
        n_vec   = 0;
        n_bad   = 0;
        bp      = 0;

        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Full sweep: window, wrap, watchdog, backpressure, then random settings.
        start = 1'b1;
        s     = cyc;
        tick();
        start = 1'b0;
        for (int k = 0; k < NS; k++) begin
            case (k)
                0: begin rate = 32'd1; epc = 1'b0; bp = 0; end
                1: begin tb_bits = 32'hFFFF_FF00; rate = 32'd1; epc = 1'b0; bp = 0; end
                2: begin rate = 32'd0; bp = 1; end
                3: begin rate = 32'd1; epc = 1'b1; bp = 20; end
                default: begin
                    rate = 32'($urandom_range(1, 9));
                    epc  = ($urandom_range(0, 1) == 1);
                    bp   = int'($urandom_range(0, 5));
                end
            endcase
            run_setting(s, k, bp, 0, h);
            s = h;
        end
        tick();
        check("sweep_done", 32'(done), 32'd1);
        check("sweep_busy", 32'(busy), 32'd0);
        check("sweep_rstn", 32'(link_rstn), 32'd0);

        // Restart from DONE, abort during setting 1's measurement.
        rate  = 32'd1;
        epc   = 1'b0;
        start = 1'b1;
        s     = cyc;
        tick();
        start = 1'b0;
        check("restart_done_clr", 32'(done), 32'd0);
        run_setting(s, 0, 0, 0, h);
        run_setting(h, 1, 0, 1, h);
        vcount = 0;
        repeat (1200) begin
            tick();
            if (result_valid !== 1'b0 || busy !== 1'b0) vcount++;
        end
        check("no_result_after_abort", 32'(vcount), 32'd0);

        // Reset during setting 1 behaves like power-on reset.
        start = 1'b1;
        s     = cyc;
        tick();
        start = 1'b0;
        run_setting(s, 0, 0, 0, h);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("midrst");

        // Abort wins over a same-cycle handshake.
        rate  = 32'($urandom_range(1, 9));
        start = 1'b1;
        s     = cyc;
        tick();
        start = 1'b0;
        run_setting(s, 0, 0, 2, h);
        tick();
        check("abhs_stays_idle", 32'(busy), 32'd0);

        finish_run();
    end

endmodule
